mc_sequencer: RTL
=================

# mc_sequencer

Multi-cycle control sequencer for the MIPS multi-cycle core. It consumes the per-instruction decoded control bundle from the opcode decoder (`CU`) and emits the cycle-by-cycle datapath strobes. The strobes are PC/IR/memory/register-file enables and mux selects, issued through the FETCH, DECODE, EXEC, MEM, WB and JUMP phases. It also handles the memory wait handshake and keeps a retired-instruction counter.

## Interface
- `CNT_W`, 16, width of retired-instruction counter
- `clock`  in  1  system clock, rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `ALUop`  in  2  decoded ALU op class from decoder
- `ALUsrc`, `Branch`, `bne`, `Jnot`, `sijal`, `MemRd`, `MemWr`, `MemtoReg`, `REGdst`, `RegWrite`  in  1 each  decoded control flags from decoder
- `zero`  in  1  ALU zero flag, valid in EXEC
- `mem_ready`  in  1  memory completes current access this cycle
- `PCWrite`  out  1  unconditional PC load
- `IorD`  out  1  memory address select (0=PC, 1=ALUOut)
- `MemRead`, `MemWrite`  out  1  memory strobes, held until `mem_ready`
- `IRWrite`  out  1  instruction register load
- `RegWr`  out  1  register-file write enable
- `RegDstSel`  out  2  00=rt, 01=rd, 10=$31
- `WbSel`  out  2  00=ALUOut, 01=MDR, 10=PC (link)
- `ALUSrcA`  out  1  0=PC, 1=rs
- `ALUSrcB`  out  2  00=rt, 01=const 4, 10=imm, 11=imm<<2
- `ALUOpOut`  out  2  ALU control class
- `PCSource`  out  2  00=ALU result, 01=ALUOut (branch target), 10=jump target
- `state`  out  3  current state encoding
- `retired`  out  `CNT_W`  retired-instruction count

## Operation
- State encoding: RST=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, JUMP=6. Codes 7 and above go to RST on the next edge.
- All outputs not listed for a state are 0.
- RST: all strobes 0. Next state is FETCH.
- FETCH: `MemRead`=1, `IorD`=0, `ALUSrcA`=0, `ALUSrcB`=01, `ALUOpOut`=00.
  - `mem_ready`=0: stay in FETCH.
  - `mem_ready`=1: same cycle `IRWrite`=1, `PCWrite`=1, `PCSource`=00. Next state is DECODE.
- DECODE: `ALUSrcA`=0, `ALUSrcB`=11, `ALUOpOut`=00. The full decoded bundle is latched into `ctl_q` on this edge.
  - `Jnot`=0: next state is JUMP.
  - Otherwise: next state is EXEC.
- EXEC: `ALUSrcA`=1. `ALUSrcB`=10 if `ctl_q.ALUsrc`, else 00.
  - Branch (`ctl_q.Branch` or `ctl_q.bne`): `ALUOpOut`=01 and `PCSource`=01. `PCWrite` = (`Branch`&`zero`)|(`bne`&~`zero`). Next state is FETCH.
  - Otherwise `ALUOpOut`=`ctl_q.ALUop`. Next state: MEM if `MemRd`|`MemWr`, else WB if `RegWrite`, else FETCH.
- MEM: `IorD`=1, `MemRead`=`ctl_q.MemRd`, `MemWrite`=`ctl_q.MemWr`.
  - Hold the state and strobes until `mem_ready`.
  - Then go to WB if `MemRd`, else FETCH.
- WB: `RegWr`=1. `RegDstSel`=01 if `ctl_q.REGdst`, else 00. `WbSel`=01 if `ctl_q.MemtoReg`, else 00. Next state is FETCH.
- JUMP: `PCWrite`=1, `PCSource`=10.
  - If `ctl_q.sijal`: also `RegWr`=1, `RegDstSel`=10, `WbSel`=10.
  - Next state is FETCH.
- `retired` increments on every transition into FETCH from EXEC, MEM, WB or JUMP. It wraps from 2^`CNT_W`-1 to 0.
- Unknown opcode (all flags 0, `Jnot`=1): FETCH, DECODE, EXEC, FETCH. It is counted as retired. No write occurs.

## Timing
- Outputs are combinational from `state`, `ctl_q`, `zero` and `mem_ready`. State, `ctl_q` and `retired` are registered.
- `resetn` low: asynchronously `state`=RST, `ctl_q`=0, `retired`=0. All strobes are 0 while in reset and for the first cycle after release.
- Asserting `resetn` low mid-instruction aborts the instruction immediately. No further strobes are issued and the count is cleared.
- Latency with zero wait states, counting FETCH through the last state:
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq/bne: 3 cycles.
  - j/jal: 3 cycles.
- Each cycle of `mem_ready`=0 in FETCH or MEM adds exactly one cycle.
- `ctl_q` is stable from the cycle after DECODE until the next DECODE. Decoder input changes during EXEC, MEM or WB have no effect.

## Test plan
- Reset release, then `mem_ready`=1 with R-type flags (`REGdst`=1, `RegWrite`=1, `ALUop`=10):
  - `state` goes 0,1,2,3,5,1.
  - `RegWr`=1 with `RegDstSel`=01 only in WB.
  - `retired` reads 1.
- lw flags with `mem_ready` low for 2 cycles in MEM:
  - MEM lasts 3 cycles with `IorD`=1 and `MemRead`=1 held.
  - WB has `WbSel`=01.
  - Total 7 cycles.
- beq with `zero`=1, then beq with `zero`=0, then bne with `zero`=0:
  - EXEC `PCWrite` is 1, 0, 1 respectively, with `PCSource`=01 each time.
- jal (`Jnot`=0, `sijal`=1):
  - JUMP has `PCWrite`=1, `PCSource`=10, `RegWr`=1, `RegDstSel`=10, `WbSel`=10.
  - j with `sijal`=0 gives the same outputs but `RegWr`=0.
- Decoder flags toggled to sw values during EXEC of an R-type:
  - WB still writes, using the latched R-type values.
- `resetn` pulsed low in MEM, and `retired` preloaded by running 65535 instructions:
  - The reset pulse gives `state`=0, all strobes 0 and `retired`=0 asynchronously.
  - One more instruction after the preload wraps `retired` to 0.

Source files
------------

// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the MIPS multi-cycle core.
// Walks FETCH/DECODE/EXEC/MEM/WB/JUMP and emits the per-cycle datapath strobes.
// The decoded control bundle is captured once per instruction in DECODE.
// A counter tracks how many instructions have retired.
module mc_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [1:0]       ALUop,
    input  logic             ALUsrc,
    input  logic             Branch,
    input  logic             bne,
    input  logic             Jnot,
    input  logic             sijal,
    input  logic             MemRd,
    input  logic             MemWr,
    input  logic             MemtoReg,
    input  logic             REGdst,
    input  logic             RegWrite,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWr,
    output logic [1:0]       RegDstSel,
    output logic [1:0]       WbSel,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOpOut,
    output logic [1:0]       PCSource,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        RST    = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        JUMP   = 3'd6
    } state_t;

    // Jnot is only needed to pick EXEC vs JUMP in DECODE, so it is not kept.
    typedef struct packed {
        logic [1:0] ALUop;
        logic       ALUsrc;
        logic       Branch;
        logic       bne;
        logic       sijal;
        logic       MemRd;
        logic       MemWr;
        logic       MemtoReg;
        logic       REGdst;
        logic       RegWrite;
    } ctl_t;

    state_t           state_q, state_d;
    ctl_t             ctl_q, ctl_d;
    logic [CNT_W-1:0] retired_q, retired_d;

    // State, latched control bundle and retire count; reset aborts any instruction.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= RST;
            ctl_q     <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            ctl_q     <= ctl_d;
            retired_q <= retired_d;
        end
    end

    // Next-state decode and combinational strobes for the current phase.
    always_comb begin
        state_d   = RST;
        ctl_d     = ctl_q;
        PCWrite   = 1'b0;
        IorD      = 1'b0;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWr     = 1'b0;
        RegDstSel = 2'b00;
        WbSel     = 2'b00;
        ALUSrcA   = 1'b0;
        ALUSrcB   = 2'b00;
        ALUOpOut  = 2'b00;
        PCSource  = 2'b00;
        case (state_q)
            RST: begin
                state_d = FETCH;
            end
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                state_d = FETCH;
                if (mem_ready) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB        = 2'b11;
                ctl_d.ALUop    = ALUop;
                ctl_d.ALUsrc   = ALUsrc;
                ctl_d.Branch   = Branch;
                ctl_d.bne      = bne;
                ctl_d.sijal    = sijal;
                ctl_d.MemRd    = MemRd;
                ctl_d.MemWr    = MemWr;
                ctl_d.MemtoReg = MemtoReg;
                ctl_d.REGdst   = REGdst;
                ctl_d.RegWrite = RegWrite;
                state_d        = Jnot ? EXEC : JUMP;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = ctl_q.ALUsrc ? 2'b10 : 2'b00;
                if (ctl_q.Branch || ctl_q.bne) begin
                    ALUOpOut = 2'b01;
                    PCSource = 2'b01;
                    PCWrite  = (ctl_q.Branch & zero) | (ctl_q.bne & ~zero);
                    state_d  = FETCH;
                end else begin
                    ALUOpOut = ctl_q.ALUop;
                    if (ctl_q.MemRd || ctl_q.MemWr) begin
                        state_d = MEM;
                    end else if (ctl_q.RegWrite) begin
                        state_d = WB;
                    end else begin
                        state_d = FETCH;
                    end
                end
            end
            MEM: begin
                IorD     = 1'b1;
                MemRead  = ctl_q.MemRd;
                MemWrite = ctl_q.MemWr;
                state_d  = MEM;
                if (mem_ready) begin
                    state_d = ctl_q.MemRd ? WB : FETCH;
                end
            end
            WB: begin
                RegWr     = 1'b1;
                RegDstSel = ctl_q.REGdst ? 2'b01 : 2'b00;
                WbSel     = ctl_q.MemtoReg ? 2'b01 : 2'b00;
                state_d   = FETCH;
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                if (ctl_q.sijal) begin
                    RegWr     = 1'b1;
                    RegDstSel = 2'b10;
                    WbSel     = 2'b10;
                end
                state_d = FETCH;
            end
            default: begin
                state_d = RST;
            end
        endcase
    end

    // An instruction retires when control returns to FETCH from a final phase.
    always_comb begin
        retired_d = retired_q;
        if (state_d == FETCH &&
            (state_q == EXEC || state_q == MEM || state_q == WB || state_q == JUMP)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule
